// File: rtl/jtkicker_scrom.sv
// Single-entry 32-bit word cache in front of a 16-bit SDRAM burst port.
// A miss fetches two beats (low half first) and fills the cache.
module jtkicker_scrom #(
  parameter int OFFSET_W = 22,
  parameter int AW       = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [AW-1:0]       addr,
  input  logic                addr_ok,
  output logic [31:0]         dout,
  output logic                data_ok,
  output logic [OFFSET_W-1:0] sdram_addr,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                sdram_dst,
  input  logic [15:0]         sdram_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_BEAT0,
    S_BEAT1
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_tag;
  logic [AW-1:0] r_pend;
  logic [31:0]   r_data;
  logic [15:0]   r_lo;
  logic          r_valid;
  logic          r_drop;

  logic                w_hit;
  logic [OFFSET_W-1:0] w_base;

  assign w_hit   = r_valid & (r_tag == addr);
  assign data_ok = addr_ok & w_hit;
  assign dout    = r_data;

  // Each 32-bit word spans two 16-bit SDRAM words
  assign w_base = offset + OFFSET_W'({addr, 1'b0});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tag      <= '0;
      r_pend     <= '0;
      r_data     <= '0;
      r_lo       <= '0;
      r_valid    <= 1'b0;
      r_drop     <= 1'b0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
    end else begin
      if (clr) r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_drop <= 1'b0;
          if (addr_ok && !w_hit) begin
            r_pend     <= addr;
            sdram_addr <= w_base;
            sdram_req  <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (clr) r_drop <= 1'b1;
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            r_state   <= S_BEAT0;
          end
        end
        S_BEAT0: begin
          if (clr) r_drop <= 1'b1;
          if (sdram_dst) begin
            r_lo    <= sdram_data;
            r_state <= S_BEAT1;
          end
        end
        S_BEAT1: begin
          if (clr) r_drop <= 1'b1;
          if (sdram_dst) begin
            r_data  <= {sdram_data, r_lo};
            r_tag   <= r_pend;
            // an invalidate seen anywhere in the burst wins
            r_valid <= !(r_drop || clr);
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtkicker_scrom.sv
// Bench for jtkicker_scrom: transaction-level cache model plus
// directed literal checks.
module tb_jtkicker_scrom;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [21:0] offset = '0;
  logic [12:0] addr = '0;
  logic        addr_ok = 1'b0;
  logic [31:0] dout;
  logic        data_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack = 1'b0;
  logic        sdram_dst = 1'b0;
  logic [15:0] sdram_data = '0;

  int checks = 0;
  int errors = 0;

  jtkicker_scrom #(.OFFSET_W(22), .AW(13)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .offset     (offset),
    .addr       (addr),
    .addr_ok    (addr_ok),
    .dout       (dout),
    .data_ok    (data_ok),
    .sdram_addr (sdram_addr),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .sdram_dst  (sdram_dst),
    .sdram_data (sdram_data)
  );

  always #5 clk = ~clk;

  // Model: one outstanding fetch, counted in beats
  bit          m_live = 0;
  bit          m_valid = 0;
  bit [12:0]   m_tag = 0;
  bit [31:0]   m_data = 0;
  bit          m_busy = 0;
  bit          m_acked = 0;
  int          m_nbeat = 0;
  bit [15:0]   m_lo = 0;
  bit [12:0]   m_pend = 0;
  int          m_addr = 0;
  bit          m_drop = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_live  <= 1;
      m_valid <= 0;
      m_tag   <= 0;
      m_data  <= 0;
      m_busy  <= 0;
      m_acked <= 0;
      m_nbeat <= 0;
      m_drop  <= 0;
      m_addr  <= 0;
    end else if (!m_busy) begin
      if (clr) m_valid <= 0;
      if (addr_ok && !(m_valid && m_tag == addr)) begin
        m_busy  <= 1;
        m_acked <= 0;
        m_nbeat <= 0;
        m_pend  <= addr;
        m_drop  <= 0;
        m_addr  <= (int'(offset) + 2 * int'(addr)) % (1 << 22);
      end
    end else begin
      if (clr) begin
        m_valid <= 0;
        m_drop  <= 1;
      end
      if (!m_acked) begin
        if (sdram_ack) m_acked <= 1;
      end else if (sdram_dst) begin
        if (m_nbeat == 0) begin
          m_lo    <= sdram_data;
          m_nbeat <= 1;
        end else begin
          m_data  <= {sdram_data, m_lo};
          m_tag   <= m_pend;
          m_valid <= !(m_drop || clr);
          m_busy  <= 0;
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      cmp("req", 32'(sdram_req), 32'(m_busy && !m_acked));
      cmp("data_ok", 32'(data_ok),
          32'(addr_ok && m_valid && m_tag == addr));
      cmp("dout", dout, m_data);
      if (m_busy && !m_acked)
        cmp("sdram_addr", 32'(sdram_addr), 32'(m_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic ackit();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
  endtask

  task automatic beat(input logic [15:0] d);
    sdram_dst  = 1'b1;
    sdram_data = d;
    tick();
    sdram_dst  = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    settle();
    cmp("rst_req", 32'(sdram_req), 32'd0);
    cmp("rst_addr", 32'(sdram_addr), 32'd0);
    cmp("rst_dout", dout, 32'd0);
    cmp("rst_ok", 32'(data_ok), 32'd0);
    tick();
    rst = 1'b0;

    // basic miss
    offset  = 22'h010000;
    addr    = 13'h0123;
    addr_ok = 1'b1;
    tick();
    settle();
    cmp("miss_req", 32'(sdram_req), 32'd1);
    cmp("miss_addr", 32'(sdram_addr), 32'h10246);
    tick();
    beat(16'h1111);
    ackit();
    settle();
    cmp("ack_req", 32'(sdram_req), 32'd0);
    beat(16'hBEEF);
    beat(16'hDEAD);
    settle();
    cmp("fill_dout", dout, 32'hDEADBEEF);
    cmp("fill_ok", 32'(data_ok), 32'd1);

    // hit, and addr_ok gating
    tick();
    tick();
    settle();
    cmp("hit_req", 32'(sdram_req), 32'd0);
    cmp("hit_ok", 32'(data_ok), 32'd1);
    addr_ok = 1'b0;
    settle();
    cmp("nok_ok", 32'(data_ok), 32'd0);

    // addr change mid-burst
    clr = 1'b1;
    tick();
    clr = 1'b0;
    addr_ok = 1'b1;
    tick();
    ackit();
    addr = 13'h0124;
    beat(16'h0001);
    beat(16'h0002);
    settle();
    cmp("chg_ok", 32'(data_ok), 32'd0);
    cmp("chg_dout", dout, 32'h00020001);
    tick();
    settle();
    cmp("chg_req", 32'(sdram_req), 32'd1);
    cmp("chg_addr", 32'(sdram_addr), 32'h10248);
    ackit();
    beat(16'h5555);
    beat(16'hAAAA);
    settle();
    cmp("chg2_dout", dout, 32'hAAAA5555);
    cmp("chg2_ok", 32'(data_ok), 32'd1);

    // clr inside BEAT1, then clr coincident with last beat
    addr = 13'h0300;
    tick();
    ackit();
    beat(16'h1234);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    beat(16'h5678);
    settle();
    cmp("clr_ok", 32'(data_ok), 32'd0);
    cmp("clr_dout", dout, 32'h56781234);
    tick();
    settle();
    cmp("clr_req", 32'(sdram_req), 32'd1);
    cmp("clr_addr", 32'(sdram_addr), 32'h10600);
    ackit();
    beat(16'h0A0A);
    clr = 1'b1;
    beat(16'h0B0B);
    clr = 1'b0;
    settle();
    cmp("clr2_ok", 32'(data_ok), 32'd0);
    tick();
    ackit();
    beat(16'h0007);
    beat(16'h0008);
    settle();
    cmp("clr3_ok", 32'(data_ok), 32'd1);
    cmp("clr3_dout", dout, 32'h00080007);

    // address wrap
    offset = 22'h3FFFFE;
    addr   = 13'h0001;
    tick();
    settle();
    cmp("wrap_req", 32'(sdram_req), 32'd1);
    cmp("wrap_addr", 32'(sdram_addr), 32'h0);
    ackit();
    beat(16'hC0DE);
    beat(16'hF00D);
    settle();
    cmp("wrap_dout", dout, 32'hF00DC0DE);
    cmp("wrap_ok", 32'(data_ok), 32'd1);

    // reset mid-burst, then a stray beat
    addr = 13'h0002;
    tick();
    ackit();
    rst = 1'b1;
    addr_ok = 1'b0;
    tick();
    rst = 1'b0;
    settle();
    cmp("rst2_req", 32'(sdram_req), 32'd0);
    cmp("rst2_ok", 32'(data_ok), 32'd0);
    cmp("rst2_dout", dout, 32'd0);
    beat(16'h9999);
    tick();
    settle();
    cmp("stray_dout", dout, 32'd0);
    cmp("stray_req", 32'(sdram_req), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
